// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter pipeline.
// Holds the capture FSM encoding, BCD digit type and default sizing
// reused by the capture and display stages.
package freq_meter_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_DIGITS = 8;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fsm_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   start        load bin and begin a conversion (ignored while busy)
//   bin          binary value to convert
//   busy         conversion in progress
//   done_c       high during the cycle that performs the final shift
//   bcd          packed BCD result, digit 0 in bits [3:0]; held after done
//   ovf          value did not fit in DIGITS decimal digits
module bin2bcd_seq
    import freq_meter_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DIGITS = DEF_DIGITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done_c,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] bin_sr;
    logic [BCD_W-1:0] dig_sr;
    logic [BCD_W-1:0] adj;
    logic             ovf_acc;
    logic [CNT_W-1:0] bit_cnt;

    // Add-3 correction per digit; no carry crosses a digit boundary.
    always_comb begin
        adj = dig_sr;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (dig_sr[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = dig_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    assign done_c = busy && (bit_cnt == CNT_W'(WIDTH - 1));

    // Shift engine; the bit leaving the top digit marks overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_sr  <= '0;
            dig_sr  <= '0;
            ovf_acc <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (start && !busy) begin
            bin_sr  <= bin;
            dig_sr  <= '0;
            ovf_acc <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            {dig_sr, bin_sr} <= {adj[BCD_W-2:0], bin_sr, 1'b0};
            ovf_acc          <= ovf_acc | adj[BCD_W-1];
            bit_cnt          <= bit_cnt + CNT_W'(1);
            if (done_c) begin
                busy <= 1'b0;
            end
        end
    end

    assign bcd = dig_sr;
    assign ovf = ovf_acc;

endmodule

// File: rtl/freq_bcd_capture.sv
// Gate-close capture and BCD conversion stage of the frequency counter.
// Snapshots counter on the falling edge of enable, converts it to BCD
// and presents a held result with a one-cycle strobe.
// Optional leading-zero blank mask: define FREQ_BCD_CAPTURE_BLANK_EN.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   counter       running count, sampled at gate close
//   enable        gate window, high while counting
//   bcd           last converted value (all nines on overflow)
//   bcd_stb       one-cycle pulse when bcd/overflow/blank update
//   overflow      last conversion exceeded the digit range
//   capture_miss  sticky, a gate closed while a conversion was running
//   blank         leading-zero mask, digit 0 never blanked (0 if disabled)
module freq_bcd_capture
    import freq_meter_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DIGITS = DEF_DIGITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    counter,
    input  logic                enable,
    output logic [4*DIGITS-1:0] bcd,
    output logic                bcd_stb,
    output logic                overflow,
    output logic                capture_miss,
    output logic [DIGITS-1:0]   blank
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam logic [BCD_W-1:0] BCD_ALL_NINE = {DIGITS{BCD_NINE}};

    fsm_t             state;
    fsm_t             state_nx;
    logic             enable_q;
    logic             gate_close;
    logic             start;
    logic             eng_busy;
    logic             eng_done_c;
    logic [BCD_W-1:0] eng_bcd;
    logic             eng_ovf;

    // Falling edge of the gate; a gate already low after reset is ignored.
    assign gate_close = enable_q & ~enable;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bin    (counter),
        .busy   (eng_busy),
        .done_c (eng_done_c),
        .bcd    (eng_bcd),
        .ovf    (eng_ovf)
    );

    // State register and gate history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            enable_q <= 1'b0;
        end else begin
            state    <= state_nx;
            enable_q <= enable;
        end
    end

    // Next-state logic; capture only from IDLE.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            IDLE: begin
                if (gate_close) begin
                    start    = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (eng_done_c) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Result registers, strobe and sticky miss flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd          <= '0;
            bcd_stb      <= 1'b0;
            overflow     <= 1'b0;
            capture_miss <= 1'b0;
        end else begin
            bcd_stb <= 1'b0;
            if (state == DONE) begin
                bcd      <= eng_ovf ? BCD_ALL_NINE : eng_bcd;
                overflow <= eng_ovf;
                bcd_stb  <= 1'b1;
            end
            if (gate_close && (state != IDLE) && !eng_busy_idle_guard(state)) begin
                capture_miss <= 1'b1;
            end
        end
    end

    // Any non-IDLE state drops the event; kept as a helper for readability.
    function automatic logic eng_busy_idle_guard(input fsm_t s);
        return (s == IDLE);
    endfunction

`ifdef FREQ_BCD_CAPTURE_BLANK_EN
    logic [DIGITS-1:0] blank_nx;
    logic              zero_hi;

    // Blank digit i when it and every higher digit are zero; never on overflow.
    always_comb begin
        blank_nx = '0;
        zero_hi  = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            zero_hi     = zero_hi & (eng_bcd[4*i +: 4] == 4'd0);
            blank_nx[i] = zero_hi & ~eng_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank <= '0;
        end else if (state == DONE) begin
            blank <= blank_nx;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: doc/freq_bcd_capture.md
Name: freq_bcd_capture

Overview:
Downstream stage of the gated frequency counter. On each gate close (falling edge of `enable`) it snapshots the 32-bit `counter`. It converts the snapshot to packed BCD with a sequential double-dabble engine, one bit per clock. It then presents the result to the display stage as a held register plus a one-cycle strobe, with overflow and missed-capture flags.

Parameters:
- WIDTH, 32, width of the binary `counter` input and of the shift engine.
- DIGITS, 8, number of BCD digits produced; values ≥ 10^DIGITS flag overflow.

Ports:
- clk  input  1  system clock, all logic single-domain.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- counter  input  WIDTH  running count from the counter stage, sampled at gate close.
- enable  input  1  gate window from the enable toggle; high = counting.
- bcd  output  4*DIGITS  last converted value, digit 0 in bits [3:0]; held between updates.
- bcd_stb  output  1  one-cycle pulse when `bcd`/`overflow` update.
- overflow  output  1  last conversion exceeded 10^DIGITS-1; qualifies `bcd`.
- capture_miss  output  1  sticky; gate closed while a conversion was in flight.
- blank  output  DIGITS  leading-zero blank mask (optional feature; otherwise tied 0).

Behaviour:
- Reset (rst=0, async): state IDLE, `bcd`=0, `bcd_stb`=0, `overflow`=0, `capture_miss`=0, `blank`=0, enable_q=0.
- Gate-close event: enable_q=1 && enable=0 (enable_q is `enable` registered once). The event occurs in the first cycle `enable` is seen low. A gate that is already low coming out of reset is not an event.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, on event:
  - load bin_sr←counter and dig_sr←0;
  - clear ovf_acc and bit_cnt←0;
  - go to SHIFT.
- SHIFT, each cycle:
  - for every digit ≥5, add 3 (4-bit, no carry between digits);
  - shift {dig_sr, bin_sr} left by 1;
  - OR the bit shifted out of the top digit's MSB into ovf_acc;
  - bit_cnt++;
  - after WIDTH shifts, go to DONE.
- DONE (one cycle):
  - `bcd`←dig_sr, or all digits 9 if ovf_acc=1;
  - `overflow`←ovf_acc;
  - `bcd_stb`=1 for this cycle only;
  - go to IDLE.
- Latency: event sampled at edge E; `bcd_stb` is visible for the cycle following edge E+WIDTH+1. Throughput is one conversion per WIDTH+2 cycles; gate period is ≫ this in practice.
- Event while in SHIFT or DONE:
  - the event is dropped and the conversion in progress continues unaffected;
  - `capture_miss`←1, which stays set until reset.
- Event and DONE in the same cycle: counts as a miss; FSM returns to IDLE.
- `counter`=0 → `bcd`=0, `overflow`=0. Counter value 2^WIDTH-1 with DIGITS=8 → overflow=1, `bcd`=0x99999999.
- Async reset mid-conversion aborts the conversion immediately; no strobe is issued.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: FREQ_BCD_CAPTURE_BLANK_EN.
- Defined:
  - `blank` is registered in DONE alongside `bcd`;
  - blank[i]=1 iff digit i and all higher digits are 0, with i>0;
  - digit 0 is never blanked;
  - on overflow, `blank`=0.
- Undefined: `blank` is constant 0 and no mask logic is synthesised.

Decomposition:
- Shared package freq_meter_pkg holds:
  - enum fsm_t {IDLE, SHIFT, DONE};
  - typedef bcd_digit_t (logic [3:0]);
  - localparam BCD_NINE=4'd9;
  - default WIDTH/DIGITS constants for reuse by the display stage.
- Sub-module bin2bcd_seq (sequential double-dabble core): start/busy/done, bin in, bcd and ovf out. freq_bcd_capture keeps edge detection, miss logic, output registers and the blank mask.

Test Plan:
- Reset, then counter=1234, enable 1→0 → `bcd_stb` one cycle at E+WIDTH+1; `bcd`=0x00001234; overflow=0; blank=8'b1111_0000 with feature on.
- counter=0 at gate close → bcd=0, overflow=0, blank=8'b1111_1110 (feature on), 0 (feature off).
- counter=99_999_999 then 100_000_000 in two gates → first 0x99999999/ovf=0, second 0x99999999/ovf=1, blank=0.
- Second falling edge of `enable` 10 cycles after the first → first result correct, only one strobe, capture_miss=1 and stays 1 across later gates.
- Assert rst=0 at shift cycle 15, release, then new gate with counter=42 → no strobe from the aborted run; `bcd`=0x00000042 after the new conversion.
- enable held low through reset release → no conversion, no strobe, bcd stays 0.
